cond_logic: RTL



---
 rtl/arm_pkg.sv | 19 +
 rtl/cond_check.sv | 40 ++++
 rtl/cond_logic.sv | 67 ++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: condition-code encoding and NZCV flag positions.
package arm_pkg;

   typedef enum logic [3:0] {
      EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
      MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
      HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
      GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator against the architectural NZCV flags.
module cond_check
   import arm_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   // NV is architecturally unpredictable; this datapath treats it as never-execute.
   always_comb begin
      CondEx = 1'b0;
      case (cond_e'(Cond))
         EQ:      CondEx = z;
         NE:      CondEx = ~z;
         CS:      CondEx = c;
         CC:      CondEx = ~c;
         MI:      CondEx = n;
         PL:      CondEx = ~n;
         VS:      CondEx = v;
         VC:      CondEx = ~v;
         HI:      CondEx = c & ~z;
         LS:      CondEx = ~c | z;
         GE:      CondEx = (n == v);
         LT:      CondEx = (n != v);
         GT:      CondEx = ~z & (n == v);
         LE:      CondEx = z | (n != v);
         AL:      CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: NZCV flag register, write/branch strobe gating and
// saturating executed/skipped instruction counters.
module cond_logic
   import arm_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   input  logic [3:0]         Cond,
   input  logic [3:0]         ALUFlags,
   input  logic [1:0]         FlagW,
   input  logic               PCS,
   input  logic               RegW,
   input  logic               MemW,
   output logic               PCSrc,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               CondEx,
   output logic [3:0]         Flags,
   output logic [COUNT_W-1:0] ExecCount,
   output logic [COUNT_W-1:0] SkipCount
);

   logic [1:0] flagWrite;

   // Evaluated from the registered flags only, so an instruction never sees its own ALU result.
   cond_check u_cond_check (
      .Cond   (Cond),
      .Flags  (Flags),
      .CondEx (CondEx)
   );

   assign flagWrite = FlagW & {2{CondEx}};
   assign PCSrc     = PCS  & CondEx;
   assign RegWrite  = RegW & CondEx;
   assign MemWrite  = MemW & CondEx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         Flags <= 4'b0000;
      end else if (en) begin
         if (flagWrite[FLAGW_NZ])
            Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
         if (flagWrite[FLAGW_CV])
            Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end
   end

   // Exactly one counter advances per retired instruction; both stick at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ExecCount <= '0;
         SkipCount <= '0;
      end else if (en) begin
         if (CondEx) begin
            if (ExecCount != '1)
               ExecCount <= ExecCount + 1'b1;
         end else begin
            if (SkipCount != '1)
               SkipCount <= SkipCount + 1'b1;
         end
      end
   end

endmodule
